// File: rtl/ext_mem_master.sv
// rtl/ext_mem_master.sv - burst master for a synchronous external data memory
// Write bursts are paced by wr_valid; read bursts issue every cycle and return data three cycles later.
module ext_mem_master #(
    parameter int DMA_SIZE = 3,
    parameter int DMD_SIZE = 4,
    parameter int LEN_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_wr,
    input  logic [DMA_SIZE-1:0] cmd_addr,
    input  logic [LEN_W-1:0]    cmd_len,
    input  logic [DMD_SIZE-1:0] wr_data,
    input  logic                wr_valid,
    output logic                wr_ready,
    output logic [DMD_SIZE-1:0] rd_data,
    output logic                rd_valid,
    output logic                done,
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DMA_SIZE-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic                cslt_q, cslt_d;
    logic                wrb_q, wrb_d;
    logic [DMA_SIZE-1:0] dm_add_q, dm_add_d;
    logic [DMD_SIZE-1:0] bc_dt_q, bc_dt_d;
    logic [DMD_SIZE-1:0] rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                done_q, done_d;
    logic [2:0]          rsr_q, rsr_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        cslt_d     = 1'b0;
        wrb_d      = wrb_q;
        dm_add_d   = dm_add_q;
        bc_dt_d    = bc_dt_q;
        done_d     = 1'b0;
        // Each stage marks a read in flight; stage 2 means data is on dm_bc_dt now.
        rsr_d      = {rsr_q[1:0], cslt_q & ~wrb_q};
        rd_valid_d = rsr_q[2];
        rd_data_d  = rsr_q[2] ? dm_bc_dt : rd_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    cnt_d   = cmd_len;
                    state_d = cmd_wr ? WRITE : READ;
                end
            end
            WRITE: begin
                if (wr_valid) begin
                    cslt_d   = 1'b1;
                    wrb_d    = 1'b1;
                    dm_add_d = addr_q;
                    bc_dt_d  = wr_data;
                    addr_d   = addr_q + DMA_SIZE'(1);
                    if (cnt_q == '0) begin
                        state_d = DRAIN;
                    end else begin
                        cnt_d = cnt_q - LEN_W'(1);
                    end
                end
            end
            READ: begin
                cslt_d   = 1'b1;
                wrb_d    = 1'b0;
                dm_add_d = addr_q;
                addr_d   = addr_q + DMA_SIZE'(1);
                if (cnt_q == '0) begin
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            DRAIN: begin
                // Leaving once the pipe empties lines done up with the final rd_valid.
                if (rsr_d == 3'b000) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            cslt_q     <= 1'b0;
            wrb_q      <= 1'b0;
            dm_add_q   <= '0;
            bc_dt_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rsr_q      <= 3'b000;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            cslt_q     <= cslt_d;
            wrb_q      <= wrb_d;
            dm_add_q   <= dm_add_d;
            bc_dt_q    <= bc_dt_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            done_q     <= done_d;
            rsr_q      <= rsr_d;
        end
    end

    assign cmd_ready  = (state_q == IDLE);
    assign wr_ready   = (state_q == WRITE);
    assign ps_dm_cslt = cslt_q;
    assign ps_dm_wrb  = wrb_q;
    assign dg_dm_add  = dm_add_q;
    assign bc_dt      = bc_dt_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_ext_mem_master.sv
// tb/tb_ext_mem_master.sv - directed bench for ext_mem_master with a 3-cycle-latency memory model
// Bus, read-return and done events are logged per cycle and compared against hand-derived values.
module tb_ext_mem_master;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_wr;
    logic [2:0] cmd_addr;
    logic [3:0] cmd_len;
    logic [3:0] wr_data;
    logic       wr_valid;
    logic       wr_ready;
    logic [3:0] rd_data;
    logic       rd_valid;
    logic       done;
    logic       ps_dm_cslt;
    logic       ps_dm_wrb;
    logic [2:0] dg_dm_add;
    logic [3:0] bc_dt;
    logic [3:0] dm_bc_dt;

    ext_mem_master dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_addr   (cmd_addr),
        .cmd_len    (cmd_len),
        .wr_data    (wr_data),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .done       (done),
        .ps_dm_cslt (ps_dm_cslt),
        .ps_dm_wrb  (ps_dm_wrb),
        .dg_dm_add  (dg_dm_add),
        .bc_dt      (bc_dt),
        .dm_bc_dt   (dm_bc_dt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: address sampled at E0, data valid after E2.
    logic [3:0] mem [8];
    logic [2:0] ra0, ra1;
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 4'h0;
        ra0 = 3'd0;
        ra1 = 3'd0;
        dm_bc_dt = 4'h0;
    end
    always @(posedge clk) begin
        if (ps_dm_cslt && ps_dm_wrb) mem[dg_dm_add] <= bc_dt;
        ra0      <= dg_dm_add;
        ra1      <= ra0;
        dm_bc_dt <= mem[ra1];
    end

    typedef struct {
        int         cyc;
        logic [2:0] addr;
        logic       wrb;
        logic [3:0] data;
    } acc_t;

    typedef struct {
        int         cyc;
        logic [3:0] data;
    } rd_t;

    int   cyc;
    acc_t acc_q[$];
    rd_t  rd_q[$];
    int   done_q[$];
    int   accept_q[$];
    int   n_cmp;
    int   n_bad;
    logic [3:0] wdata [16];

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (ps_dm_cslt) acc_q.push_back('{cyc, dg_dm_add, ps_dm_wrb, bc_dt});
            if (rd_valid) rd_q.push_back('{cyc, rd_data});
            if (done) done_q.push_back(cyc);
            if (cmd_valid && cmd_ready) accept_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        acc_q.delete();
        rd_q.delete();
        done_q.delete();
        accept_q.delete();
    endtask

    task automatic wait_done(input int n);
        for (int k = 0; k < 200 && done_q.size() < n; k++) begin
            @(negedge clk);
            #1;
        end
        if (done_q.size() < n) check("done_timeout", 32'(done_q.size()), 32'(n));
        repeat (3) step();
    endtask

    task automatic run_write(input logic [2:0] a, input logic [3:0] len, input int gap);
        clear_logs();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b1;
        cmd_addr  = a;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (i == gap) begin
                wr_valid = 1'b0;
                step();
            end
            wr_valid = 1'b1;
            wr_data  = wdata[i];
            step();
        end
        wr_valid = 1'b0;
        wait_done(1);
    endtask

    task automatic run_read(input logic [2:0] a, input logic [3:0] len);
        clear_logs();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = a;
        cmd_len   = len;
        step();
        cmd_valid = 1'b0;
        wait_done(1);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_len   = 4'd0;
        wr_data   = 4'd0;
        wr_valid  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cslt", 32'(ps_dm_cslt), 0);
        check("rst_wrb", 32'(ps_dm_wrb), 0);
        check("rst_add", 32'(dg_dm_add), 0);
        check("rst_bc_dt", 32'(bc_dt), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_rd_valid", 32'(rd_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_wr_ready", 32'(wr_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_cmd_ready", 32'(cmd_ready), 1);

        // Continuous write A,B,C,D at 2..5
        wdata[0] = 4'hA; wdata[1] = 4'hB; wdata[2] = 4'hC; wdata[3] = 4'hD;
        run_write(3'd2, 4'd3, -1);
        check("w1_nacc", 32'(acc_q.size()), 4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            check($sformatf("w1_addr%0d", i), 32'(acc_q[i].addr), 32'(2 + i));
            check($sformatf("w1_wrb%0d", i), 32'(acc_q[i].wrb), 1);
            check($sformatf("w1_data%0d", i), 32'(acc_q[i].data), 32'(10 + i));
            check($sformatf("w1_cyc%0d", i), 32'(acc_q[i].cyc - acc_q[0].cyc), 32'(i));
        end
        check("w1_ndone", 32'(done_q.size()), 1);
        if (done_q.size() > 0 && acc_q.size() == 4)
            check("w1_done_cyc", 32'(done_q[0] - acc_q[3].cyc), 1);

        // Read back 2..5
        run_read(3'd2, 4'd3);
        check("r1_nacc", 32'(acc_q.size()), 4);
        for (int i = 0; i < 4 && i < acc_q.size(); i++) begin
            check($sformatf("r1_addr%0d", i), 32'(acc_q[i].addr), 32'(2 + i));
            check($sformatf("r1_wrb%0d", i), 32'(acc_q[i].wrb), 0);
        end
        check("r1_nrd", 32'(rd_q.size()), 4);
        for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
            check($sformatf("r1_data%0d", i), 32'(rd_q[i].data), 32'(10 + i));
            check($sformatf("r1_rcyc%0d", i), 32'(rd_q[i].cyc - rd_q[0].cyc), 32'(i));
        end
        if (rd_q.size() == 4 && acc_q.size() > 0) begin
            check("r1_latency", 32'(rd_q[0].cyc - acc_q[0].cyc), 4);
            if (done_q.size() > 0) check("r1_done_cyc", 32'(done_q[0]), 32'(rd_q[3].cyc));
        end
        check("r1_ndone", 32'(done_q.size()), 1);

        // Write 1,2,3 at 6,7,0 with one stall before the second word
        wdata[0] = 4'h1; wdata[1] = 4'h2; wdata[2] = 4'h3;
        run_write(3'd6, 4'd2, 1);
        check("w2_nacc", 32'(acc_q.size()), 3);
        if (acc_q.size() == 3) begin
            check("w2_addr0", 32'(acc_q[0].addr), 6);
            check("w2_addr1", 32'(acc_q[1].addr), 7);
            check("w2_addr2", 32'(acc_q[2].addr), 0);
            check("w2_gap", 32'(acc_q[1].cyc - acc_q[0].cyc), 2);
            check("w2_next", 32'(acc_q[2].cyc - acc_q[1].cyc), 1);
            if (done_q.size() > 0) check("w2_done_cyc", 32'(done_q[0] - acc_q[2].cyc), 1);
        end
        check("w2_ndone", 32'(done_q.size()), 1);

        // Wrapping read 7,0
        run_read(3'd7, 4'd1);
        check("r2_nacc", 32'(acc_q.size()), 2);
        if (acc_q.size() == 2) begin
            check("r2_addr0", 32'(acc_q[0].addr), 7);
            check("r2_addr1", 32'(acc_q[1].addr), 0);
        end
        check("r2_nrd", 32'(rd_q.size()), 2);
        if (rd_q.size() == 2) begin
            check("r2_data0", 32'(rd_q[0].data), 2);
            check("r2_data1", 32'(rd_q[1].data), 3);
        end

        // Single-word write then immediate read of the same address
        wdata[0] = 4'h5;
        run_write(3'd4, 4'd0, -1);
        check("w3_nacc", 32'(acc_q.size()), 1);
        run_read(3'd4, 4'd0);
        check("r3_nacc", 32'(acc_q.size()), 1);
        check("r3_nrd", 32'(rd_q.size()), 1);
        if (rd_q.size() == 1) check("r3_data", 32'(rd_q[0].data), 5);

        // Maximum length: 16 words over 0..7 twice
        for (int i = 0; i < 16; i++) wdata[i] = 4'(i);
        run_write(3'd0, 4'd15, -1);
        check("w4_nacc", 32'(acc_q.size()), 16);
        if (acc_q.size() == 16) begin
            check("w4_addr8", 32'(acc_q[8].addr), 0);
            check("w4_addr15", 32'(acc_q[15].addr), 7);
            check("w4_data15", 32'(acc_q[15].data), 15);
        end
        run_read(3'd0, 4'd15);
        check("r4_nrd", 32'(rd_q.size()), 16);
        if (rd_q.size() == 16) begin
            check("r4_data0", 32'(rd_q[0].data), 8);
            check("r4_data5", 32'(rd_q[5].data), 13);
            check("r4_data15", 32'(rd_q[15].data), 15);
        end
        check("r4_ndone", 32'(done_q.size()), 1);

        // Reset during the third word of a len=7 read
        clear_logs();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 3'd0;
        cmd_len   = 4'd7;
        step();
        cmd_valid = 1'b0;
        for (int k = 0; k < 50 && acc_q.size() < 3; k++) begin
            @(negedge clk);
            #1;
        end
        check("rr_reached3", 32'(acc_q.size()), 3);
        rst_n = 1'b0;
        #1;
        check("rr_cslt", 32'(ps_dm_cslt), 0);
        check("rr_add", 32'(dg_dm_add), 0);
        check("rr_rd_valid", 32'(rd_valid), 0);
        check("rr_rd_data", 32'(rd_data), 0);
        check("rr_done", 32'(done), 0);
        clear_logs();
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("rr_cmd_ready", 32'(cmd_ready), 1);
        repeat (10) step();
        check("rr_nacc", 32'(acc_q.size()), 0);
        check("rr_nrd", 32'(rd_q.size()), 0);
        check("rr_ndone", 32'(done_q.size()), 0);

        // cmd_valid held high: the second command waits for done
        clear_logs();
        cmd_valid = 1'b1;
        cmd_wr    = 1'b0;
        cmd_addr  = 3'd1;
        cmd_len   = 4'd1;
        for (int k = 0; k < 100 && done_q.size() == 0; k++) begin
            @(negedge clk);
            #1;
        end
        step();
        cmd_valid = 1'b0;
        wait_done(2);
        check("hold_naccept", 32'(accept_q.size()), 2);
        if (accept_q.size() == 2 && done_q.size() > 0)
            check("hold_accept_cyc", 32'(accept_q[1]), 32'(done_q[0]));
        check("hold_ndone", 32'(done_q.size()), 2);
        check("hold_nrd", 32'(rd_q.size()), 4);
        if (rd_q.size() == 4) begin
            check("hold_data1", 32'(rd_q[1].data), 10);
            check("hold_data2", 32'(rd_q[2].data), 9);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
